mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 44 ++++
 rtl/mem_bus_arbiter.sv | 108 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and the shared memory/IO bus.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_bus_arbiter_if;
    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        err;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata,
        output err
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata,
        input  err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for a shared memory/IO bus, with per-transfer timeout.
// Latency: grant one cycle after a request is seen in IDLE; bus request is combinational from the granted requester.
// Backpressure: the granted requester waits on s_ready; the other requester's request is held pending, never dropped.
module mem_bus_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        ptr, ptr_nxt;          // 1: m1 wins the next tie
    logic [7:0]  wait_cnt, wait_cnt_nxt;

    logic        sel;
    logic        req_vld;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_rdy;
    logic [31:0] rsp_dat;
    logic        timeout_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        sel       = (state == GNT1);
        req_vld   = sel ? bus.m1_valid : bus.m0_valid;
        req_addr  = sel ? bus.m1_addr  : bus.m0_addr;
        req_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
        req_wstrb = sel ? bus.m1_wstrb : bus.m0_wstrb;
        timeout_hit = (TIMEOUT != 8'd0) && (wait_cnt == TIMEOUT) && !bus.s_ready;
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        wait_cnt_nxt = wait_cnt;
        rsp_rdy      = 1'b0;
        rsp_dat      = 32'd0;
        bus.s_valid  = 1'b0;
        bus.s_addr   = 32'd0;
        bus.s_wdata  = 32'd0;
        bus.s_wstrb  = 4'd0;
        bus.err      = 1'b0;

        case (state)
            IDLE: begin
                wait_cnt_nxt = 8'd0;
                if (bus.m0_valid && bus.m1_valid) begin
                    state_nxt = ptr ? GNT1 : GNT0;
                end else if (bus.m0_valid) begin
                    state_nxt = GNT0;
                end else if (bus.m1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                bus.s_valid = req_vld;
                bus.s_addr  = req_addr;
                bus.s_wdata = req_wdata;
                bus.s_wstrb = req_wstrb;
                if (bus.s_ready) begin
                    rsp_rdy   = 1'b1;
                    rsp_dat   = bus.s_rdata;
                    state_nxt = IDLE;
                    ptr_nxt   = !sel;
                end else if (!req_vld) begin
                    // requester withdrew: no response, fairness untouched
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    rsp_rdy     = 1'b1;
                    rsp_dat     = 32'hFFFF_FFFF;
                    bus.err     = 1'b1;
                    bus.s_valid = 1'b0;
                    state_nxt   = IDLE;
                    ptr_nxt     = !sel;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        bus.m0_ready = rsp_rdy && !sel;
        bus.m1_ready = rsp_rdy && sel;
        bus.m0_rdata = (rsp_rdy && !sel) ? rsp_dat : 32'd0;
        bus.m1_rdata = (rsp_rdy && sel)  ? rsp_dat : 32'd0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transfer-owner model checked every cycle plus literal spot checks.
module tb_mem_bus_arbiter;
    localparam int TO = 4;

    logic clk;
    logic resetn;
    int   n_total;
    int   n_bad;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.TIMEOUT(8'd4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus (-1 none), who wins the next tie, and the cycle the grant began.
    int          own;
    int          nxt_own;
    int          fav;
    int          cyc;
    int          t_grant;
    logic        e_rdy;
    logic        e_sv;
    logic        e_err;
    logic        v;
    logic [31:0] e_dat;

    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            own = -1;
            fav = 0;
            chk("rst_s_valid", {31'd0, bus.s_valid}, 32'd0);
            chk("rst_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
            chk("rst_m1_ready", {31'd0, bus.m1_ready}, 32'd0);
            chk("rst_err", {31'd0, bus.err}, 32'd0);
        end else begin
            e_rdy = 1'b0; e_sv = 1'b0; e_err = 1'b0; e_dat = 32'd0;
            nxt_own = own;
            if (own < 0) begin
                if (bus.m0_valid && bus.m1_valid) nxt_own = fav;
                else if (bus.m0_valid)            nxt_own = 0;
                else if (bus.m1_valid)            nxt_own = 1;
                t_grant = cyc + 1;
                chk("idle_s_wstrb", {28'd0, bus.s_wstrb}, 32'd0);
            end else begin
                v = (own == 0) ? bus.m0_valid : bus.m1_valid;
                if (bus.s_ready) begin
                    e_rdy = 1'b1; e_dat = bus.s_rdata; e_sv = v;
                    nxt_own = -1; fav = 1 - own;
                end else if (!v) begin
                    nxt_own = -1;
                end else if (TO != 0 && (cyc - t_grant) == TO) begin
                    e_rdy = 1'b1; e_dat = 32'hFFFF_FFFF; e_err = 1'b1;
                    nxt_own = -1; fav = 1 - own;
                end else begin
                    e_sv = 1'b1;
                end
                chk("m_s_addr",  bus.s_addr,  own == 0 ? bus.m0_addr : bus.m1_addr);
                chk("m_s_wdata", bus.s_wdata, own == 0 ? bus.m0_wdata : bus.m1_wdata);
                chk("m_s_wstrb", {28'd0, bus.s_wstrb}, {28'd0, own == 0 ? bus.m0_wstrb : bus.m1_wstrb});
            end
            chk("m_s_valid",  {31'd0, bus.s_valid},  {31'd0, e_sv});
            chk("m_m0_ready", {31'd0, bus.m0_ready}, {31'd0, e_rdy && own == 0});
            chk("m_m1_ready", {31'd0, bus.m1_ready}, {31'd0, e_rdy && own == 1});
            chk("m_err",      {31'd0, bus.err},      {31'd0, e_err});
            if (e_rdy && own == 0) chk("m_m0_rdata", bus.m0_rdata, e_dat);
            if (e_rdy && own == 1) chk("m_m1_rdata", bus.m1_rdata, e_dat);
            own = nxt_own;
        end
    end

    task automatic do_reset();
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    int order[$];
    int exp_order[4];

    initial begin
        n_total = 0; n_bad = 0; cyc = 0; own = -1; fav = 0; t_grant = 0;
        resetn = 1'b0;
        bus.m0_valid = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
        bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
        bus.s_ready = 0; bus.s_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_s_valid", {31'd0, bus.s_valid}, 32'd0);
        chk("reset_err", {31'd0, bus.err}, 32'd0);
        resetn = 1'b1;

        // single read
        step();
        bus.m0_valid = 1; bus.m0_addr = 32'h100; bus.m0_wstrb = 4'b0000;
        step(); #1;
        chk("rd_c1_s_valid", {31'd0, bus.s_valid}, 32'd1);
        chk("rd_c1_s_addr", bus.s_addr, 32'h100);
        chk("rd_c1_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
        step();
        bus.s_ready = 1; bus.s_rdata = 32'hDEADBEEF; #1;
        chk("rd_c2_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
        chk("rd_c2_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        step();
        bus.s_ready = 0; #1;
        chk("rd_c3_idle", {31'd0, bus.s_valid}, 32'd0);
        bus.m0_valid = 0;

        // slave ready while idle is ignored
        step();
        bus.s_ready = 1; #1;
        chk("idle_rdy_m0", {31'd0, bus.m0_ready}, 32'd0);
        chk("idle_rdy_err", {31'd0, bus.err}, 32'd0);
        step();
        bus.s_ready = 0;

        // write routing from m1
        bus.m1_valid = 1; bus.m1_addr = 32'h8000; bus.m1_wdata = 32'h5A; bus.m1_wstrb = 4'b0001;
        step(); #1;
        chk("wr_s_addr", bus.s_addr, 32'h8000);
        chk("wr_s_wdata", bus.s_wdata, 32'h5A);
        chk("wr_s_wstrb", {28'd0, bus.s_wstrb}, 32'd1);
        bus.s_ready = 1; #1;
        chk("wr_m1_ready", {31'd0, bus.m1_ready}, 32'd1);
        chk("wr_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
        step();
        bus.s_ready = 0; bus.m1_valid = 0; bus.m1_wstrb = 0;

        // contention from reset: both hold requests, slave answers at once
        do_reset();
        bus.m0_valid = 1; bus.m0_addr = 32'hA0;
        bus.m1_valid = 1; bus.m1_addr = 32'hB0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            step();
            bus.s_ready = 0; #1;
            bus.s_ready = bus.s_valid; bus.s_rdata = 32'h1000 + c; #1;
            if (bus.m0_ready) order.push_back(0);
            if (bus.m1_ready) order.push_back(1);
        end
        step();
        bus.s_ready = 0; bus.m0_valid = 0; bus.m1_valid = 0;
        chk("cont_count", order.size(), 32'd4);
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            chk("cont_order", (i < order.size()) ? order[i] : -1, exp_order[i]);

        // timeout on unmapped address with m1 pending
        do_reset();
        bus.m0_valid = 1; bus.m0_addr = 32'hDEAD0000;
        bus.m1_valid = 1; bus.m1_addr = 32'h2000;
        for (int i = 1; i <= 5; i++) begin
            step(); #1;
            if (i < 5) begin
                chk("to_wait_err", {31'd0, bus.err}, 32'd0);
                chk("to_wait_s_valid", {31'd0, bus.s_valid}, 32'd1);
            end else begin
                chk("to_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
                chk("to_m0_rdata", bus.m0_rdata, 32'hFFFFFFFF);
                chk("to_err", {31'd0, bus.err}, 32'd1);
                chk("to_s_valid", {31'd0, bus.s_valid}, 32'd0);
                chk("to_m1_ready", {31'd0, bus.m1_ready}, 32'd0);
            end
        end
        bus.m0_valid = 0;
        step(); #1;
        chk("to_idle", {31'd0, bus.s_valid}, 32'd0);
        step(); #1;
        chk("to_m1_grant", bus.s_addr, 32'h2000);
        bus.s_ready = 1; bus.s_rdata = 32'h1234; #1;
        chk("to_m1_done", {31'd0, bus.m1_ready}, 32'd1);
        step();
        bus.s_ready = 0; bus.m1_valid = 0;

        // reset in the middle of an m1 transfer
        step();
        bus.m1_valid = 1; bus.m1_addr = 32'h3000;
        step(); #1;
        chk("rm_gnt1", {31'd0, bus.s_valid}, 32'd1);
        step();
        resetn = 0; #1;
        chk("rm_s_valid", {31'd0, bus.s_valid}, 32'd0);
        chk("rm_m1_ready", {31'd0, bus.m1_ready}, 32'd0);
        bus.m0_valid = 1; bus.m0_addr = 32'h4000;
        step();
        resetn = 1;
        step(); #1;
        chk("rm_m0_wins", bus.s_addr, 32'h4000);
        bus.s_ready = 1; #1;
        chk("rm_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
        step();
        bus.s_ready = 0; bus.m0_valid = 0;
        step(); #1;
        chk("rm_m1_next", bus.s_addr, 32'h3000);
        bus.s_ready = 1; #1;
        chk("rm_m1_ready", {31'd0, bus.m1_ready}, 32'd1);
        step();
        bus.s_ready = 0; bus.m1_valid = 0;

        // abort: m0 withdraws mid-grant
        step();
        bus.m0_valid = 1; bus.m0_addr = 32'h5000;
        step();
        step();
        bus.m0_valid = 0; #1;
        chk("ab_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
        chk("ab_err", {31'd0, bus.err}, 32'd0);
        chk("ab_s_valid", {31'd0, bus.s_valid}, 32'd0);
        step();
        bus.m0_valid = 1; #1;
        chk("ab_idle", {31'd0, bus.s_valid}, 32'd0);
        step(); #1;
        chk("ab_regrant", {31'd0, bus.s_valid}, 32'd1);
        bus.s_ready = 1;
        step();
        bus.s_ready = 0; bus.m0_valid = 0;

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, bad=%0d", n_bad);
        $fatal(1);
    end
endmodule
